// File: rtl/pc_stack_fetch_if.sv
// Control-unit <-> fetch-unit bundle: decoded flow-control flags and irq in,
// instruction address and return-stack status out.
interface pc_stack_fetch_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned SP_W = $clog2(DEPTH) + 1;

  logic            s_jmp;
  logic            s_call;
  logic            s_ret;
  logic            s_reti;
  logic [PC_W-1:0] target;
  logic            irq;

  logic [PC_W-1:0] pc;
  logic [SP_W-1:0] sp;
  logic            in_isr;
  logic            stack_ovf;
  logic            stack_unf;

  modport master (
    output s_jmp, s_call, s_ret, s_reti, target, irq,
    input  pc, sp, in_isr, stack_ovf, stack_unf
  );

  modport slave (
    input  s_jmp, s_call, s_ret, s_reti, target, irq,
    output pc, sp, in_isr, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_stack_fetch.sv
// Program counter with return-address stack, jump/call/ret/reti handling and
// a single-level rising-edge interrupt entry.
module pc_stack_fetch #(
  parameter int unsigned     PC_W     = 10,
  parameter int unsigned     DEPTH    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] IRQ_VEC  = PC_W'(10'h3F0)
) (
  input  logic               clk,
  input  logic               reset,
  pc_stack_fetch_if.slave    bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned SP_W = AW + 1;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_ISR = 1'b1
  } mode_t;

  mode_t           mode_q, mode_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            pend_q, pend_d;
  logic            irq_q;

  logic [PC_W-1:0] stack_mem [DEPTH];
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] stack_top;
  logic [PC_W-1:0] push_data;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   wr_idx;
  logic            push_en;
  logic            mem_we;
  logic            stack_full;
  logic            stack_empty;
  logic            irq_edge;
  logic            accept;

  assign pc_inc      = pc_q + PC_W'(1);
  assign pc_seq      = bus.s_jmp ? bus.target : pc_inc;
  assign stack_full  = (sp_q == SP_W'(DEPTH));
  assign stack_empty = (sp_q == '0);
  assign rd_idx      = AW'(sp_q - SP_W'(1));
  assign wr_idx      = AW'(sp_q);
  assign stack_top   = stack_mem[rd_idx];
  assign irq_edge    = bus.irq & ~irq_q;

  // State register: everything except the stack storage itself is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_RUN;
      pc_q   <= RESET_PC;
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      pend_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pc_q   <= pc_d;
      sp_q   <= sp_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      pend_q <= pend_d;
      irq_q  <= bus.irq;
    end
  end

  // Next-state: reti > ret > call > irq entry > jmp > increment.
  always_comb begin
    mode_d    = mode_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push_en   = 1'b0;
    push_data = pc_inc;

    accept = pend_q && (mode_q == MODE_RUN) &&
             !(bus.s_call || bus.s_ret || bus.s_reti);

    if (bus.s_reti || bus.s_ret) begin
      if (bus.s_reti) begin
        mode_d = MODE_RUN;
      end
      if (stack_empty) begin
        unf_d = 1'b1;
        pc_d  = RESET_PC;
      end else begin
        pc_d = stack_top;
        sp_d = sp_q - SP_W'(1);
      end
    end else if (bus.s_call) begin
      push_en   = 1'b1;
      push_data = pc_inc;
      pc_d      = bus.target;
    end else if (accept) begin
      // The interrupted flow resumes where it would have gone this cycle.
      push_en   = 1'b1;
      push_data = pc_seq;
      pc_d      = IRQ_VEC;
      mode_d    = MODE_ISR;
    end else begin
      pc_d = pc_seq;
    end

    if (push_en) begin
      if (stack_full) begin
        ovf_d = 1'b1;
      end else begin
        sp_d = sp_q + SP_W'(1);
      end
    end

    // An edge seen on the acceptance cycle survives as a fresh request.
    pend_d = (pend_q && !accept) || irq_edge;
  end

  assign mem_we = push_en && !stack_full;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      stack_mem[wr_idx] <= push_data;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.sp        = sp_q;
  assign bus.in_isr    = (mode_q == MODE_ISR);
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;

  sp_in_range: assert property (@(posedge clk) disable iff (reset) sp_q <= SP_W'(DEPTH));

endmodule

// File: tb/tb_pc_stack_fetch.sv
// Directed vector bench for pc_stack_fetch: tables of per-edge stimulus with
// hand-computed pc/sp/flag expectations plus reset and overflow sequences.
module tb_pc_stack_fetch;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned DEPTH = 8;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_CALL = 4'b0100;
  localparam logic [3:0] OP_RET  = 4'b0010;
  localparam logic [3:0] OP_RETI = 4'b0001;

  typedef struct {
    logic [3:0]      op;   // {jmp, call, ret, reti}
    logic [PC_W-1:0] tgt;
    logic            irq;
    logic [PC_W-1:0] pc;
    logic [3:0]      sp;
    logic [2:0]      fl;   // {in_isr, stack_ovf, stack_unf}
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  vec_t tab_a [$];
  vec_t tab_b [$];

  pc_stack_fetch_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  pc_stack_fetch #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] op, input logic [PC_W-1:0] tgt,
                              input logic irq, input logic [PC_W-1:0] pc,
                              input logic [3:0] sp, input logic [2:0] fl);
    vec_t v;
    v.op = op; v.tgt = tgt; v.irq = irq; v.pc = pc; v.sp = sp; v.fl = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [PC_W-1:0] pc,
                             input logic [3:0] sp, input logic [2:0] fl);
    check({tag, ".pc"}, 32'(bus.pc), 32'(pc));
    check({tag, ".sp"}, 32'(bus.sp), 32'(sp));
    check({tag, ".flags"}, 32'({bus.in_isr, bus.stack_ovf, bus.stack_unf}), 32'(fl));
  endtask

  task automatic apply(input vec_t v, input string tag);
    {bus.s_jmp, bus.s_call, bus.s_ret, bus.s_reti} = v.op;
    bus.target = v.tgt;
    bus.irq    = v.irq;
    @(posedge clk);
    #1;
    check_state(tag, v.pc, v.sp, v.fl);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.s_jmp = 1'b0; bus.s_call = 1'b0; bus.s_ret = 1'b0; bus.s_reti = 1'b0;
    bus.target = '0;  bus.irq = 1'b0;

    // Basic flow, nested calls, wrap and priority
    tab_a.push_back(mk(OP_NONE, 10'h000, 1'b0, 10'h001, 4'd0, 3'b000));
    tab_a.push_back(mk(OP_NONE, 10'h000, 1'b0, 10'h002, 4'd0, 3'b000));
    tab_a.push_back(mk(OP_JMP,  10'h010, 1'b0, 10'h010, 4'd0, 3'b000));
    tab_a.push_back(mk(OP_CALL, 10'h100, 1'b0, 10'h100, 4'd1, 3'b000));
    tab_a.push_back(mk(OP_CALL, 10'h200, 1'b0, 10'h200, 4'd2, 3'b000));
    tab_a.push_back(mk(OP_NONE, 10'h000, 1'b0, 10'h201, 4'd2, 3'b000));
    tab_a.push_back(mk(OP_RET,  10'h000, 1'b0, 10'h101, 4'd1, 3'b000));
    tab_a.push_back(mk(OP_RET,  10'h000, 1'b0, 10'h011, 4'd0, 3'b000));
    tab_a.push_back(mk(OP_JMP,  10'h3FF, 1'b0, 10'h3FF, 4'd0, 3'b000));
    tab_a.push_back(mk(OP_NONE, 10'h000, 1'b0, 10'h000, 4'd0, 3'b000));
    tab_a.push_back(mk(OP_NONE, 10'h000, 1'b0, 10'h001, 4'd0, 3'b000));
    tab_a.push_back(mk(OP_JMP | OP_CALL, 10'h050, 1'b0, 10'h050, 4'd1, 3'b000));
    tab_a.push_back(mk(OP_JMP | OP_CALL | OP_RET, 10'h123, 1'b0, 10'h002, 4'd0, 3'b000));

    // Interrupt entry, deferral, collapsing, underflow on reti
    tab_b.push_back(mk(OP_JMP,  10'h020, 1'b0, 10'h020, 4'd0, 3'b000));
    tab_b.push_back(mk(OP_JMP,  10'h020, 1'b1, 10'h020, 4'd0, 3'b000));
    tab_b.push_back(mk(OP_JMP,  10'h040, 1'b1, 10'h3F0, 4'd1, 3'b100));
    tab_b.push_back(mk(OP_NONE, 10'h000, 1'b1, 10'h3F1, 4'd1, 3'b100));
    tab_b.push_back(mk(OP_RETI, 10'h000, 1'b1, 10'h040, 4'd0, 3'b000));
    tab_b.push_back(mk(OP_NONE, 10'h000, 1'b0, 10'h041, 4'd0, 3'b000));
    tab_b.push_back(mk(OP_NONE, 10'h000, 1'b1, 10'h042, 4'd0, 3'b000));
    tab_b.push_back(mk(OP_CALL, 10'h060, 1'b1, 10'h060, 4'd1, 3'b000));
    tab_b.push_back(mk(OP_NONE, 10'h000, 1'b1, 10'h3F0, 4'd2, 3'b100));
    tab_b.push_back(mk(OP_NONE, 10'h000, 1'b0, 10'h3F1, 4'd2, 3'b100));
    tab_b.push_back(mk(OP_NONE, 10'h000, 1'b1, 10'h3F2, 4'd2, 3'b100));
    tab_b.push_back(mk(OP_NONE, 10'h000, 1'b0, 10'h3F3, 4'd2, 3'b100));
    tab_b.push_back(mk(OP_NONE, 10'h000, 1'b1, 10'h3F4, 4'd2, 3'b100));
    tab_b.push_back(mk(OP_RETI, 10'h000, 1'b0, 10'h061, 4'd1, 3'b000));
    tab_b.push_back(mk(OP_NONE, 10'h000, 1'b0, 10'h3F0, 4'd2, 3'b100));
    tab_b.push_back(mk(OP_RETI, 10'h000, 1'b0, 10'h062, 4'd1, 3'b000));
    tab_b.push_back(mk(OP_NONE, 10'h000, 1'b0, 10'h063, 4'd1, 3'b000));
    tab_b.push_back(mk(OP_RET,  10'h000, 1'b0, 10'h043, 4'd0, 3'b000));
    tab_b.push_back(mk(OP_RETI, 10'h000, 1'b0, 10'h000, 4'd0, 3'b001));
    tab_b.push_back(mk(OP_CALL, 10'h070, 1'b1, 10'h070, 4'd1, 3'b001));
    tab_b.push_back(mk(OP_CALL, 10'h071, 1'b0, 10'h071, 4'd2, 3'b001));
    tab_b.push_back(mk(OP_NONE, 10'h000, 1'b1, 10'h3F0, 4'd3, 3'b101));
    tab_b.push_back(mk(OP_RETI, 10'h000, 1'b0, 10'h072, 4'd2, 3'b001));
    tab_b.push_back(mk(OP_NONE, 10'h000, 1'b0, 10'h3F0, 4'd3, 3'b101));

    #1;
    check_state("por", 10'h000, 4'd0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check_state("por_hold", 10'h000, 4'd0, 3'b000);
    reset = 1'b0;

    for (int i = 0; i < tab_a.size(); i++) begin
      apply(tab_a[i], $sformatf("a%0d", i));
    end

    // Nine calls from pc=0x002: the ninth overflows without a write
    for (int i = 0; i < 9; i++) begin
      apply(mk(OP_CALL, 10'(10'h080 + i), 1'b0, 10'(10'h080 + i),
               (i < 8) ? 4'(i + 1) : 4'd8, (i == 8) ? 3'b010 : 3'b000),
            $sformatf("ovf_call%0d", i));
    end
    // Stack holds 0x003, 0x081..0x087; the ninth pop underflows
    for (int j = 0; j < 9; j++) begin
      apply(mk(OP_RET, 10'h000, 1'b0,
               (j < 7) ? 10'(10'h087 - j) : ((j == 7) ? 10'h003 : 10'h000),
               (j < 8) ? 4'(7 - j) : 4'd0, (j == 8) ? 3'b011 : 3'b010),
            $sformatf("unf_ret%0d", j));
    end

    // Reset mid-run at pc=0x005, sp=2, asserted between edges
    apply(mk(OP_CALL, 10'h004, 1'b0, 10'h004, 4'd1, 3'b011), "mid_call0");
    apply(mk(OP_CALL, 10'h005, 1'b0, 10'h005, 4'd2, 3'b011), "mid_call1");
    bus.s_call = 1'b0;
    reset = 1'b1;
    #1;
    check_state("mid_reset", 10'h000, 4'd0, 3'b000);
    #1;
    reset = 1'b0;
    apply(mk(OP_NONE, 10'h000, 1'b0, 10'h001, 4'd0, 3'b000), "rel0");
    apply(mk(OP_NONE, 10'h000, 1'b0, 10'h002, 4'd0, 3'b000), "rel1");
    apply(mk(OP_NONE, 10'h000, 1'b0, 10'h003, 4'd0, 3'b000), "rel2");

    for (int i = 0; i < tab_b.size(); i++) begin
      apply(tab_b[i], $sformatf("b%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
